// File: rtl/mem_arbiter.sv
// Round-robin arbiter that serialises word requests from NUM_CH pipeline
// channels into 1-4 byte transactions on the 8-bit RAM/IO bus.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int NUM_CH = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH-1:0]        req_wr,
  input  logic [32*NUM_CH-1:0]     req_addr,
  input  logic [2*NUM_CH-1:0]      req_len,
  input  logic [32*NUM_CH-1:0]     req_wdata,
  input  logic [NUM_CH-1:0]        req_cancel,
  output logic [NUM_CH-1:0]        req_ready,
  output logic [NUM_CH-1:0]        resp_valid,
  output logic [31:0]              resp_rdata,
  output logic                     busy,
  input  logic                     io_buffer_full,
  input  logic [7:0]               mem_din,
  output logic [7:0]               mem_dout,
  output logic [31:0]              mem_a,
  output logic                     mem_wr,
  output logic [1:0]               state_dbg
);

  // Handshake: req_ready[k] is a one-cycle grant pulse taken whenever it is
  // high (the request is consumed that cycle); resp_valid[k] is a one-cycle
  // completion pulse with no back-pressure from the channel.
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   prio;
  logic [CW-1:0]   ch;
  logic [31:0]     base;
  logic [1:0]      len;
  logic [31:0]     wdata;
  logic [2:0]      cnt;
  logic [31:0]     rbuf;

  logic            gnt_found;
  logic [CW-1:0]   gnt_ch;
  logic [CW-1:0]   next_prio;
  logic            sel_wr;
  logic [31:0]     sel_addr;
  logic [31:0]     sel_wdata;
  logic [1:0]      sel_len;
  int              idx;

  logic [2:0]      len_ext;
  logic [31:0]     cur_addr;
  logic            io_hold;
  logic [1:0]      rd_byte;
  logic [31:0]     rbuf_next;
  logic [NUM_CH-1:0] ch_onehot;

  // First requester at or after the rotating pointer wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_ch    = '0;
    next_prio = '0;
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_len   = '0;
    idx       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(prio) + i) % NUM_CH;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_ch    = CW'(idx);
        next_prio = CW'((idx + 1) % NUM_CH);
        sel_wr    = req_wr[idx];
        sel_addr  = req_addr[32*idx +: 32];
        sel_wdata = req_wdata[32*idx +: 32];
        sel_len   = req_len[2*idx +: 2];
      end
    end
  end

  assign req_ready = (rst_in && rdy_in && (state == IDLE) && gnt_found)
                     ? (NUM_CH'(1) << gnt_ch) : '0;

  assign len_ext   = {1'b0, len};
  assign cur_addr  = base + 32'(cnt);
  assign io_hold   = (cur_addr[17:16] == 2'b11) && io_buffer_full;
  assign rd_byte   = 2'(cnt - 3'd1);
  assign ch_onehot = NUM_CH'(1) << ch;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // The byte arriving now belongs to the address presented one cycle earlier.
  always_comb begin
    rbuf_next = rbuf;
    rbuf_next[8*rd_byte +: 8] = mem_din;
  end

  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    case (state)
      RD: begin
        if (!rdy_in) begin
          // Re-present the pending address so the RAM output is valid on resume.
          mem_a = (cnt == 3'd0) ? base : base + 32'(cnt - 3'd1);
        end else if (cnt > len_ext) begin
          mem_a = base + 32'(len);
        end else begin
          mem_a = cur_addr;
        end
      end
      WR: begin
        mem_a    = cur_addr;
        mem_dout = wdata[8*cnt[1:0] +: 8];
        mem_wr   = rdy_in && !io_hold;
      end
      default: begin
        mem_a    = '0;
        mem_dout = '0;
        mem_wr   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= IDLE;
      prio       <= '0;
      ch         <= '0;
      base       <= '0;
      len        <= '0;
      wdata      <= '0;
      cnt        <= '0;
      rbuf       <= '0;
      resp_valid <= '0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= '0;
      if (rdy_in) begin
        case (state)
          IDLE: begin
            if (gnt_found) begin
              ch    <= gnt_ch;
              base  <= sel_addr;
              len   <= sel_len;
              wdata <= sel_wdata;
              cnt   <= '0;
              rbuf  <= '0;
              prio  <= next_prio;
              state <= sel_wr ? WR : RD;
            end
          end
          RD: begin
            if (req_cancel[ch]) begin
              state <= IDLE;
            end else begin
              if (cnt != 3'd0) rbuf <= rbuf_next;
              if (cnt == len_ext + 3'd1) begin
                resp_valid <= ch_onehot;
                resp_rdata <= rbuf_next;
                state      <= IDLE;
              end else begin
                cnt <= cnt + 3'd1;
              end
            end
          end
          WR: begin
            if (!io_hold) begin
              if (cnt == len_ext) begin
                resp_valid <= ch_onehot;
                resp_rdata <= '0;
                state      <= IDLE;
              end else begin
                cnt <= cnt + 3'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
